// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter: captures a WIDTH-bit word on load, shifts it out one bit
// per clock with a valid strobe, then pulses done. Optional even-parity bit via PISO_PARITY_EN.
module piso_serializer #(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    output logic             ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             done
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

`ifdef PISO_PARITY_EN
    typedef enum logic [1:0] {StIdle, StShift, StParity, StDone} state_e;
`else
    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;
`endif

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CntW-1:0]  count_q, count_d;
`ifdef PISO_PARITY_EN
    logic             parity_q, parity_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            shreg_q  <= '0;
            count_q  <= '0;
`ifdef PISO_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            count_q  <= count_d;
`ifdef PISO_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // Outputs decode only registered state, so load/data_in never reach an output combinationally.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        count_d   = count_q;
`ifdef PISO_PARITY_EN
        parity_d  = parity_q;
`endif
        ready     = 1'b0;
        ser_valid = 1'b0;
        ser_out   = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            StIdle: begin
                ready = 1'b1;
                if (load) begin
                    shreg_d  = data_in;
                    count_d  = '0;
`ifdef PISO_PARITY_EN
                    parity_d = ^data_in;
`endif
                    state_d  = StShift;
                end
            end
            StShift: begin
                ser_valid = 1'b1;
                ser_out   = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
                shreg_d   = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
                if (count_q == LastCnt) begin
`ifdef PISO_PARITY_EN
                    state_d = StParity;
`else
                    state_d = StDone;
`endif
                end else begin
                    count_d = count_q + CntW'(1);
                end
            end
`ifdef PISO_PARITY_EN
            StParity: begin
                ser_valid = 1'b1;
                ser_out   = parity_q;
                state_d   = StDone;
            end
`endif
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

endmodule
